// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the PC and the IF/ID register.
// Issues in-order word fetches to an instruction memory with variable latency,
// pairs each returned word with its PC and hands pc/inst/pc+4 to decode over a
// valid/ready handshake. A redirect flushes the queue, restarts fetch at a new
// PC and discards every response still in flight.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   defined   - a live response that fills the head slot is presented on out_*
//               in the same cycle (combinational path mem_rsp_* -> out_*).
//   undefined - registered-only output.
//
// Ports:
//   clk                      clock, rising edge
//   rst_n                    synchronous reset, active high (rst_n=1 resets)
//   redirect, redirect_pc    flush and restart fetch at redirect_pc
//   mem_req_valid/ready/addr fetch request channel (word aligned address)
//   mem_rsp_valid/data       in-order response strobe, no backpressure
//   out_valid/ready          head entry handshake towards decode
//   out_pc/inst/pc_add4      head entry payload, 0 when out_valid=0
//   count                    slots allocated (requested or filled)

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc_add4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // Stale responses from before a redirect are still outstanding while new
    // slots are requested, so the in-flight tally can exceed DEPTH.
    localparam int IW = CW + 4;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [DEPTH-1:0] r_fill;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_fill_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_fetch_pc;
    logic [IW-1:0]    r_inflight;
    logic [IW-1:0]    r_drop;

    logic w_rsp;
    logic w_rsp_live;
    logic w_req_valid;
    logic w_fire;
    logic w_bypass;
    logic w_out_valid;
    logic w_pop;
    logic w_fill_store;

    // A response with nothing in flight is a protocol violation and is ignored.
    assign w_rsp       = mem_rsp_valid & (r_inflight != '0);
    assign w_rsp_live  = w_rsp & (r_drop == '0) & ~redirect;
    assign w_req_valid = ~rst_n & ~redirect & (r_count < FULL);
    assign w_fire      = w_req_valid & mem_req_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Head is reserved but still waiting, and this response is the one it waits for.
    assign w_bypass = w_rsp_live & (r_fill_ptr == r_rd_ptr) & ~r_fill[r_rd_ptr] & (r_count != '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out_valid  = r_fill[r_rd_ptr] | w_bypass;
    assign w_pop        = w_out_valid & out_ready & ~redirect;
    // A bypassed word consumed in the same cycle never needs to be stored.
    assign w_fill_store = w_rsp_live & ~(w_bypass & out_ready);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_fill     <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect) begin
            r_fill     <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= redirect_pc;
            // Everything still outstanding after this cycle's response is stale.
            r_inflight <= r_inflight - IW'(w_rsp);
            r_drop     <= r_inflight - IW'(w_rsp);
        end else begin
            if (w_pop) begin
                r_fill[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + AW'(1);
            end
            if (w_rsp) begin
                if (r_drop != '0) begin
                    r_drop <= r_drop - IW'(1);
                end else begin
                    if (w_fill_store) begin
                        r_inst[r_fill_ptr] <= mem_rsp_data;
                        r_fill[r_fill_ptr] <= 1'b1;
                    end
                    r_fill_ptr <= r_fill_ptr + AW'(1);
                end
            end
            if (w_fire) begin
                r_pc[r_wr_ptr]   <= {r_fetch_pc[31:2], 2'b00};
                r_fill[r_wr_ptr] <= 1'b0;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
                r_fetch_pc       <= r_fetch_pc + 32'd4;
            end
            r_count    <= r_count + CW'(w_fire) - CW'(w_pop);
            r_inflight <= r_inflight + IW'(w_fire) - IW'(w_rsp);
        end
    end

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = {r_fetch_pc[31:2], 2'b00};
    assign out_valid     = w_out_valid;
    assign out_pc        = w_out_valid ? r_pc[r_rd_ptr] : 32'd0;
    assign out_pc_add4   = w_out_valid ? (r_pc[r_rd_ptr] + 32'd4) : 32'd0;
    assign out_inst      = !w_out_valid ? 32'd0 : (w_bypass ? mem_rsp_data : r_inst[r_rd_ptr]);
    assign count         = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic          out_valid, out_ready;
    logic [31:0]   redirect_pc, mem_req_addr, mem_rsp_data, out_pc, out_inst, out_pc_add4;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_pc_add4(out_pc_add4), .count(count)
    );

    // Reference model: the queue as a list of allocated entries in program order,
    // plus the number of stale responses still to be thrown away.
    typedef struct { logic [31:0] pc; logic [31:0] inst; bit filled; } ent_t;
    typedef struct { logic [31:0] data; int due; } mrsp_t;
    ent_t        mq[$];
    mrsp_t       memq[$];
    int          mdrop;
    logic [31:0] mfpc;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit cur_rsp_real;

    logic        exp_valid, exp_req_valid;
    logic [31:0] exp_pc, exp_inst, exp_add4, exp_addr;
    int          exp_count;
    bit          exp_rsp_eff;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    // Drive one cycle's inputs (memory responses come from memq) and predict outputs.
    task automatic apply(input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit mready, input bit oready, input bit spur);
        bit byp;
        rst_n = rst; redirect = redir; redirect_pc = rpc;
        mem_req_ready = mready; out_ready = oready;
        cur_rsp_real = 1'b0;
        if (spur) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = memq[0].data; cur_rsp_real = 1'b1;
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        end
        exp_rsp_eff = mem_rsp_valid && (unfilled() + mdrop) > 0;
        byp = (BYP != 0) && exp_rsp_eff && !redir && mdrop == 0 && mq.size() > 0 && !mq[0].filled;
        exp_valid     = (mq.size() > 0 && mq[0].filled) || byp;
        exp_pc        = exp_valid ? mq[0].pc : 32'd0;
        exp_add4      = exp_valid ? mq[0].pc + 32'd4 : 32'd0;
        exp_inst      = !exp_valid ? 32'd0 : (byp ? mem_rsp_data : mq[0].inst);
        exp_req_valid = !rst && !redir && mq.size() < DEPTH;
        exp_addr      = mfpc;
        exp_count     = mq.size();
        #2;
    endtask

    task automatic advance();
        bit   pop;
        ent_t e;
        @(posedge clk);
        if (rst_n) begin
            mq.delete(); memq.delete(); mdrop = 0; mfpc = RESET_PC;
        end else begin
            if (cur_rsp_real) void'(memq.pop_front());
            if (redirect) begin
                mdrop = unfilled() + mdrop - (exp_rsp_eff ? 1 : 0);
                mq.delete();
                mfpc = redirect_pc;
            end else begin
                pop = exp_valid && out_ready;
                if (exp_rsp_eff) begin
                    if (mdrop > 0) mdrop--;
                    else begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!mq[i].filled) begin
                                e = mq[i]; e.filled = 1'b1; e.inst = mem_rsp_data; mq[i] = e;
                                break;
                            end
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (exp_req_valid && mem_req_ready) begin
                    mq.push_back('{pc: mfpc, inst: 32'd0, filled: 1'b0});
                    memq.push_back('{data: memfn(mfpc), due: cyc + int'($urandom_range(lat_max, lat_min))});
                    mfpc = mfpc + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        n_chk++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_in_reset: got %0b want 0", mem_req_valid); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_chk++; if (out_pc !== 32'd0 || out_inst !== 32'd0 || out_pc_add4 !== 32'd0) begin
            n_err++; $display("FAIL reset_payload: got pc=%h inst=%h add4=%h want 0", out_pc, out_inst, out_pc_add4); end
        n_chk++; if (mem_req_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", mem_req_addr, RESET_PC); end
        n_chk++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL reset_first_req: got %0b want 1", mem_req_valid); end
        advance();
    endtask

    task automatic test_stream();
        int first = -1;
        int lag   = 2 - BYP;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            n_chk++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(k * 4)) begin
                n_err++; $display("FAIL stream_req[%0d]: got v=%0b a=%h want v=1 a=%h", k, mem_req_valid, mem_req_addr, 32'(k * 4)); end
            if (out_valid === 1'b1 && first < 0) first = k;
            if (k >= lag) begin
                n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'((k - lag) * 4) || out_pc_add4 !== 32'((k - lag) * 4 + 4)
                             || out_inst !== memfn(32'((k - lag) * 4))) begin
                    n_err++; $display("FAIL stream_out[%0d]: got v=%0b pc=%h add4=%h inst=%h want pc=%h", k, out_valid, out_pc,
                                      out_pc_add4, out_inst, 32'((k - lag) * 4)); end
            end
            advance();
        end
        n_chk++; if (first != lag) begin n_err++; $display("FAIL stream_latency: got %0d want %0d", first, lag); end
    endtask

    task automatic test_full();
        int issued = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (mem_req_valid === 1'b1) issued++;
            advance();
        end
        n_chk++; if (issued != DEPTH) begin n_err++; $display("FAIL full_issued: got %0d want %0d", issued, DEPTH); end
        apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        n_chk++; if (count !== CW'(DEPTH) || mem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd0) begin
            n_err++; $display("FAIL full_pop_cycle: got cnt=%0d rv=%0b ov=%0b pc=%h want 4 0 1 0", count, mem_req_valid, out_valid, out_pc); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        n_chk++; if (count !== CW'(DEPTH - 1) || mem_req_valid !== 1'b1 || mem_req_addr !== 32'd16 || out_pc !== 32'd4) begin
            n_err++; $display("FAIL full_refill: got cnt=%0d rv=%0b a=%h pc=%h want 3 1 10 4", count, mem_req_valid, mem_req_addr, out_pc); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        n_chk++; if (count !== CW'(DEPTH) || mem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL full_again: got cnt=%0d rv=%0b want 4 0", count, mem_req_valid); end
        advance();
    endtask

    // Runs until the first delivered entry; checks its PC and how many responses preceded it.
    task automatic wait_first(input string nm, input logic [31:0] want_pc, input int want_rsp);
        int nrsp = 0;
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (k == 0) begin
                n_chk++; if (out_valid !== 1'b0 || count !== '0 || mem_req_valid !== 1'b1 || mem_req_addr !== want_pc) begin
                    n_err++; $display("FAIL %s_restart: got ov=%0b cnt=%0d rv=%0b a=%h want 0 0 1 %h", nm, out_valid, count,
                                      mem_req_valid, mem_req_addr, want_pc); end
            end
            if (out_valid === 1'b1) begin
                seen = 1;
                n_chk++; if (out_pc !== want_pc || out_inst !== memfn(want_pc)) begin
                    n_err++; $display("FAIL %s_first_pc: got pc=%h inst=%h want %h", nm, out_pc, out_inst, want_pc); end
                n_chk++; if (nrsp != want_rsp) begin
                    n_err++; $display("FAIL %s_dropped: got %0d responses before delivery want %0d", nm, nrsp, want_rsp); end
            end
            if (mem_rsp_valid) nrsp++;
            advance();
        end
        n_chk++; if (!seen) begin n_err++; $display("FAIL %s_timeout: got no out_valid want delivery", nm); end
    endtask

    task automatic test_redirect();
        lat_min = 8; lat_max = 8;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            advance();
        end
        apply(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        n_chk++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_req_blocked: got %0b want 0", mem_req_valid); end
        advance();
        lat_min = 1; lat_max = 1;
        wait_first("redir", 32'h100, 4 - BYP);
    endtask

    task automatic test_redirect_collision();
        int ndrop;
        lat_min = 2; lat_max = 2;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            advance();
        end
        apply(1'b0, 1'b1, 32'h2000, 1'b1, 1'b1, 1'b0);
        ndrop = memq.size() - 1;
        n_chk++; if (out_valid !== 1'b1 || mem_rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL coll_setup: got ov=%0b rsp=%0b want 1 1", out_valid, mem_rsp_valid); end
        advance();
        wait_first("coll", 32'h2000, ndrop + 1 - BYP);
    endtask

    task automatic test_wrap();
        int lag = 2 - BYP;
        lat_min = 1; lat_max = 1;
        do_reset();
        apply(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        advance();
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (k == 1) begin
                n_chk++; if (mem_req_addr !== 32'd0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", mem_req_addr); end
            end
            if (k == lag) begin
                n_chk++; if (out_pc !== 32'hFFFF_FFFC || out_pc_add4 !== 32'd0) begin
                    n_err++; $display("FAIL wrap_add4: got pc=%h add4=%h want fffffffc 0", out_pc, out_pc_add4); end
            end
            if (k == lag + 1) begin
                n_chk++; if (out_pc !== 32'd0 || out_pc_add4 !== 32'd4) begin
                    n_err++; $display("FAIL wrap_next: got pc=%h add4=%h want 0 4", out_pc, out_pc_add4); end
            end
            advance();
        end
    endtask

    task automatic test_spurious();
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 2; k++) begin apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0); advance(); end
        for (int k = 0; k < 3; k++) begin apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0); advance(); end
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_chk++; if (count !== CW'(2) || out_valid !== 1'b1 || out_pc !== 32'd0 || out_inst !== memfn(32'd0)) begin
            n_err++; $display("FAIL spur_filled: got cnt=%0d ov=%0b pc=%h inst=%h want 2 1 0 %h", count, out_valid, out_pc, out_inst, memfn(32'd0)); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_chk++; if (out_pc !== 32'd4) begin n_err++; $display("FAIL spur_second: got pc=%h want 4", out_pc); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        n_chk++; if (out_valid !== 1'b0 || count !== '0) begin
            n_err++; $display("FAIL spur_empty: got ov=%0b cnt=%0d want 0 0", out_valid, count); end
        advance();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_chk++; if (out_valid !== 1'b0 || count !== '0 || mem_req_addr !== 32'd8) begin
            n_err++; $display("FAIL spur_after_empty: got ov=%0b cnt=%0d a=%h want 0 0 8", out_valid, count, mem_req_addr); end
        advance();
    endtask

    task automatic test_random();
        bit          rst, redir, spur;
        logic [31:0] rpc;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) lat_max = int'($urandom_range(6, 1));
            rst   = ($urandom_range(199, 0) == 0);
            redir = !rst && ($urandom_range(99, 0) < 4);
            rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            spur  = !rst && memq.size() == 0 && ($urandom_range(29, 0) == 0);
            apply(rst, redir, rpc, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7, spur);
            n_chk++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %0b want %0b", k, out_valid, exp_valid); end
            n_chk++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL rnd_out_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
            n_chk++; if (out_inst !== exp_inst) begin n_err++; $display("FAIL rnd_out_inst[%0d]: got %h want %h", k, out_inst, exp_inst); end
            n_chk++; if (out_pc_add4 !== exp_add4) begin n_err++; $display("FAIL rnd_add4[%0d]: got %h want %h", k, out_pc_add4, exp_add4); end
            n_chk++; if (count !== CW'(exp_count)) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", k, count, exp_count); end
            n_chk++; if (mem_req_valid !== exp_req_valid) begin n_err++; $display("FAIL rnd_req_valid[%0d]: got %0b want %0b", k, mem_req_valid, exp_req_valid); end
            n_chk++; if (mem_req_addr !== exp_addr) begin n_err++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", k, mem_req_addr, exp_addr); end
            advance();
        end
    endtask

    initial begin
        mdrop = 0;
        mfpc  = RESET_PC;
        #1;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_collision();
        test_wrap();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
